// File: rtl/sopc_run_ctrl_pkg.sv
// Shared state codes and reset polarity for the SOPC run controller.
package sopc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  // Reset is active-low throughout the SOPC, for both rst and cpu_rst_o.
  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  function automatic logic is_terminal(run_state_e s);
    return (s == ST_HALTED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sopc_run_ctrl_pc_stall_detector.sv
// Flags a CPU self-loop: the fetch PC held at one value for HALT_REPEAT
// consecutive enabled cycles. clr forgets history so the next sample is fresh.
module pc_stall_detector
  import sopc_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            stall
);

  localparam logic [7:0] RepLast = 8'(HALT_REPEAT);

  logic [PC_W-1:0] pc_prev_q;
  logic            valid_q;
  logic [7:0]      rep_q, rep_d;

  always_comb begin
    rep_d = 8'd1;
    if (valid_q && (pc == pc_prev_q)) begin
      rep_d = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
    end
  end

  assign stall = en && (rep_d == RepLast);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      pc_prev_q <= '0;
      valid_q   <= 1'b0;
      rep_q     <= 8'd0;
    end else if (en) begin
      pc_prev_q <= pc;
      valid_q   <= 1'b1;
      rep_q     <= rep_d;
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for the MIPS32 SOPC: holds the CPU in reset, then runs it
// until a PC self-loop (halt), the cycle limit, or a soft restart.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int RST_HOLD    = 5,
  parameter int MAX_CYCLES  = 25,
  parameter int HALT_REPEAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             wb_we_i,
  output logic             cpu_rst_o,
  output logic             run_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o,
  output logic             done_o,
  output logic             halted_o,
  output logic             timeout_o
);

  localparam logic [7:0]       HoldLast = 8'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_CYCLES);

  run_state_e       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic [CNT_W-1:0] wb_q, wb_d;
  logic             cpu_rst_q, run_q, done_q, halted_q, timeout_q;
  logic             stall;

  pc_stall_detector #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart_i || (state_q != ST_RUN)),
    .en    (state_q == ST_RUN),
    .pc    (pc_i),
    .stall (stall)
  );

  assign cyc_inc = (cyc_q == CntMax) ? cyc_q : cyc_q + CntOne;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    wb_d    = wb_q;
    if (restart_i) begin
      state_d = ST_HOLD;
      hold_d  = 8'd0;
      cyc_d   = '0;
      wb_d    = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          hold_d = hold_q + 8'd1;
          if (hold_q == HoldLast) state_d = ST_RUN;
        end
        ST_RUN: begin
          cyc_d = cyc_inc;
          if (wb_we_i && (wb_q != CntMax)) wb_d = wb_q + CntOne;
          // Halt is checked first so a simultaneous limit hit reports as a halt.
          if (stall) begin
            state_d = ST_HALTED;
          end else if ((MAX_CYCLES != 0) && (cyc_inc == MaxCnt)) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= ST_HOLD;
      hold_q    <= 8'd0;
      cyc_q     <= '0;
      wb_q      <= '0;
      cpu_rst_q <= RstEnable;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cyc_q     <= cyc_d;
      wb_q      <= wb_d;
      cpu_rst_q <= (state_d == ST_HOLD) ? RstEnable : RstDisable;
      run_q     <= (state_d == ST_RUN);
      done_q    <= is_terminal(state_d);
      halted_q  <= (state_d == ST_HALTED);
      timeout_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign cpu_rst_o   = cpu_rst_q;
  assign run_o       = run_q;
  assign cycle_cnt_o = cyc_q;
  assign wb_cnt_o    = wb_q;
  assign done_o      = done_q;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: three parameterisations driven by shared inputs,
// checked against a cycle-level behavioural model plus directed sequences.
module tb_sopc_run_ctrl;

  localparam int NI       = 3;
  localparam int RST_HOLD = 5;
  localparam int HALT_REP = 4;
  localparam int M_HOLD   = 0;
  localparam int M_RUN    = 1;
  localparam int M_HALT   = 2;
  localparam int M_TOUT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] pc = 32'h0;

  logic        cpu_rst_a, run_a, done_a, halted_a, timeout_a;
  logic        cpu_rst_b, run_b, done_b, halted_b, timeout_b;
  logic        cpu_rst_c, run_c, done_c, halted_c, timeout_c;
  logic [15:0] cyc_a, wb_a, cyc_b, wb_b;
  logic [3:0]  cyc_c, wb_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sopc_run_ctrl #(.PC_W(32), .CNT_W(16), .RST_HOLD(RST_HOLD), .MAX_CYCLES(25), .HALT_REPEAT(HALT_REP)) u_dut_a (
    .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc), .wb_we_i(wb_we),
    .cpu_rst_o(cpu_rst_a), .run_o(run_a), .cycle_cnt_o(cyc_a), .wb_cnt_o(wb_a),
    .done_o(done_a), .halted_o(halted_a), .timeout_o(timeout_a));

  sopc_run_ctrl #(.PC_W(32), .CNT_W(16), .RST_HOLD(RST_HOLD), .MAX_CYCLES(8), .HALT_REPEAT(HALT_REP)) u_dut_b (
    .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc), .wb_we_i(wb_we),
    .cpu_rst_o(cpu_rst_b), .run_o(run_b), .cycle_cnt_o(cyc_b), .wb_cnt_o(wb_b),
    .done_o(done_b), .halted_o(halted_b), .timeout_o(timeout_b));

  sopc_run_ctrl #(.PC_W(32), .CNT_W(4), .RST_HOLD(RST_HOLD), .MAX_CYCLES(0), .HALT_REPEAT(HALT_REP)) u_dut_c (
    .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc), .wb_we_i(wb_we),
    .cpu_rst_o(cpu_rst_c), .run_o(run_c), .cycle_cnt_o(cyc_c), .wb_cnt_o(wb_c),
    .done_o(done_c), .halted_o(halted_c), .timeout_o(timeout_c));

  // Reference model: per-instance phase, counters, and the PC trace since RUN entry.
  int          p_max  [NI] = '{25, 8, 0};
  int          p_cmax [NI] = '{65535, 65535, 15};
  int          m_mode [NI];
  int          m_hold [NI];
  int          m_cyc  [NI];
  int          m_wb   [NI];
  logic [31:0] run_pcs[$];

  typedef struct {
    bit          r;
    bit          rs;
    logic [31:0] pc;
    bit          we;
    logic [36:0] exp;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] rpc;
  bit          rr, rrs, rwe;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] act_of(int i);
    case (i)
      0:       return 64'({cpu_rst_a, run_a, done_a, halted_a, timeout_a, cyc_a, wb_a});
      1:       return 64'({cpu_rst_b, run_b, done_b, halted_b, timeout_b, cyc_b, wb_b});
      default: return 64'({cpu_rst_c, run_c, done_c, halted_c, timeout_c, 12'h0, cyc_c, 12'h0, wb_c});
    endcase
  endfunction

  function automatic logic [63:0] exp_of(int i);
    return 64'({m_mode[i] != M_HOLD, m_mode[i] == M_RUN, m_mode[i] >= M_HALT,
                m_mode[i] == M_HALT, m_mode[i] == M_TOUT, 16'(m_cyc[i]), 16'(m_wb[i])});
  endfunction

  task automatic model_edge(bit r, bit rs, logic [31:0] p, bit we);
    int rep;
    if (!r || rs) run_pcs.delete();
    else if (m_mode[0] != M_HOLD) run_pcs.push_back(p);
    rep = 0;
    for (int j = run_pcs.size() - 1; j >= 0; j--) begin
      if (run_pcs[j] != p || rep == HALT_REP) break;
      rep++;
    end
    for (int i = 0; i < NI; i++) begin
      if (!r || rs) begin
        m_mode[i] = M_HOLD; m_hold[i] = 0; m_cyc[i] = 0; m_wb[i] = 0;
      end else if (m_mode[i] == M_HOLD) begin
        m_hold[i]++;
        if (m_hold[i] == RST_HOLD) m_mode[i] = M_RUN;
      end else if (m_mode[i] == M_RUN) begin
        if (m_cyc[i] < p_cmax[i]) m_cyc[i]++;
        if (we && m_wb[i] < p_cmax[i]) m_wb[i]++;
        if (rep >= HALT_REP) m_mode[i] = M_HALT;
        else if (p_max[i] != 0 && m_cyc[i] == p_max[i]) m_mode[i] = M_TOUT;
      end
    end
  endtask

  task automatic tick(bit r, bit rs, logic [31:0] p, bit we);
    rst = r; restart = rs; pc = p; wb_we = we;
    @(posedge clk);
    model_edge(r, rs, p, we);
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("model_inst%0d", i), act_of(i), exp_of(i));
  endtask

  task automatic start_run(string tag);
    int n;
    tick(1'b1, 1'b1, 32'h0, 1'b0);
    chk({tag, "_restart_edge"}, 64'({cpu_rst_a, run_a, done_a, halted_a, timeout_a, cyc_a, wb_a}), 64'h0);
    n = 0;
    while (!cpu_rst_a && n < 20) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      n++;
    end
    chk({tag, "_hold_len"}, 64'(n), 64'd5);
    chk({tag, "_run_rise"}, 64'({run_a, cyc_a}), 64'({1'b1, 16'd0}));
  endtask

  task automatic add_vec(bit r, bit rs, logic [31:0] p, bit we, bit e_cr, bit e_run,
                         int e_cyc, int e_wb, bit e_done, bit e_halt, bit e_tout);
    vec_t v;
    v.r = r; v.rs = rs; v.pc = p; v.we = we;
    v.exp = {e_cr, e_run, e_done, e_halt, e_tout, 16'(e_cyc), 16'(e_wb)};
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = M_HOLD; m_hold[i] = 0; m_cyc[i] = 0; m_wb[i] = 0;
    end

    // Reset, release, RUN with PC 4,8 then a self-loop at 0xC (0x0 shown during hold).
    for (int i = 0; i < 3; i++) add_vec(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add_vec(1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0);
    add_vec(1, 0, 32'h4, 1, 1, 1, 1, 1, 0, 0, 0);
    add_vec(1, 0, 32'h8, 0, 1, 1, 2, 1, 0, 0, 0);
    add_vec(1, 0, 32'hC, 1, 1, 1, 3, 2, 0, 0, 0);
    add_vec(1, 0, 32'hC, 0, 1, 1, 4, 2, 0, 0, 0);
    add_vec(1, 0, 32'hC, 0, 1, 1, 5, 2, 0, 0, 0);
    add_vec(1, 0, 32'hC, 1, 1, 0, 6, 3, 1, 1, 0);
    add_vec(1, 0, 32'hC, 1, 1, 0, 6, 3, 1, 1, 0);
    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].r, vq[i].rs, vq[i].pc, vq[i].we);
      chk($sformatf("vec%0d", i), act_of(0), 64'(vq[i].exp));
    end

    // Timeout at the 25-cycle limit with writes on odd run cycles.
    start_run("timeout");
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, 1'b0, 32'(4 * k), k[0]);
      if (done_a) break;
    end
    chk("timeout_a", 64'({done_a, halted_a, timeout_a, cyc_a, wb_a}), 64'({3'b101, 16'd25, 16'd13}));

    // Halt and limit qualify together at cycle 8 on the MAX_CYCLES=8 instance.
    start_run("tie");
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0, (k < 5) ? 32'(4 * k) : 32'd20, 1'b0);
      if (done_b) break;
    end
    chk("tie_b", 64'({done_b, halted_b, timeout_b, cyc_b}), 64'({3'b110, 16'd8}));

    // Restart mid-run at cycle 10.
    start_run("pre_mid");
    for (int k = 1; k <= 30; k++) begin
      tick(1'b1, 1'b0, 32'(4 * k), 1'b1);
      if (cyc_a == 16'd10) break;
    end
    chk("mid_reach10", 64'({run_a, cyc_a, wb_a}), 64'({1'b1, 16'd10, 16'd10}));
    start_run("restart_mid");
    tick(1'b1, 1'b0, 32'h100, 1'b0);
    chk("mid_fresh_run", 64'({run_a, cyc_a, wb_a}), 64'({1'b1, 16'd1, 16'd0}));

    // 4-bit counters saturate with the limit disabled.
    start_run("sat");
    for (int k = 1; k <= 20; k++) tick(1'b1, 1'b0, 32'(4 * k), 1'b1);
    chk("sat_c", 64'({done_c, run_c, cyc_c, wb_c}), 64'({2'b01, 4'hF, 4'hF}));

    // Random traffic against the model.
    rpc = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      rr  = ($urandom_range(0, 99) != 0);
      rrs = ($urandom_range(0, 39) == 0);
      rwe = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0, 1, 2: rpc = rpc;
        3, 4:    rpc = rpc + 32'd4;
        default: rpc = $urandom() & 32'h0000_FFFC;
      endcase
      tick(rr, rrs, rpc, rwe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
